life_cell_gen: RTL

LIFE_CELL_GEN -- requirements
Module: life_cell_gen

---
 rtl/life_cell_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/life_cell_gen.sv
// life_cell_gen: one cell of a Life / Generations cellular automaton.
// Holds the cell state, the count of consecutive generations it has been alive,
// the previous alive flag, and one-cycle born/died pulses. The cell advances
// one generation per enabled clock edge, or is loaded from val on a write.
module life_cell_gen #(
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
    parameter int         STATES       = 2,
    parameter int         AGE_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             n,
    input  logic             ne,
    input  logic             e,
    input  logic             se,
    input  logic             s,
    input  logic             sw,
    input  logic             w,
    input  logic             nw,
    input  logic             write,
    input  logic             val,
    input  logic             enb,
    output logic             alive,
    output logic             alive_prev,
    output logic [3:0]       state,
    output logic [AGE_W-1:0] age,
    output logic             born,
    output logic             died
);

    // Highest legal state code; with STATES == 2 this is the alive state itself.
    localparam logic [3:0]       LAST_STATE = 4'(STATES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX    = {AGE_W{1'b1}};

    logic [3:0]       count_s;
    logic [3:0]       next_state_s;
    logic [3:0]       state_r;
    logic [AGE_W-1:0] age_r;
    logic             alive_r;
    logic             alive_prev_r;
    logic             born_r;
    logic             died_r;

    // Live-neighbour count, 0..8, used to index the birth and survive masks.
    always_comb begin
        count_s = {3'b000, n}  + {3'b000, ne} + {3'b000, e}  + {3'b000, se}
                + {3'b000, s}  + {3'b000, sw} + {3'b000, w}  + {3'b000, nw};
    end

    // Generation rule: birth from dead, survival or decay from alive, and a
    // fixed march through the dying states back to dead. Dying cells ignore
    // neighbours; unreachable codes at or above STATES fall back to dead.
    always_comb begin
        next_state_s = 4'd0;
        if (state_r == 4'd0) begin
            if (BIRTH_MASK[count_s]) begin
                next_state_s = 4'd1;
            end else begin
                next_state_s = 4'd0;
            end
        end else if (state_r == 4'd1) begin
            if (SURVIVE_MASK[count_s]) begin
                next_state_s = 4'd1;
            end else if (STATES == 2) begin
                next_state_s = 4'd0;
            end else begin
                next_state_s = 4'd2;
            end
        end else if (state_r < LAST_STATE) begin
            next_state_s = state_r + 4'd1;
        end else begin
            next_state_s = 4'd0;
        end
    end

    // Cell registers: reset beats write, write beats a step, otherwise hold
    // with the event pulses cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= 4'd0;
            alive_r      <= 1'b0;
            age_r        <= '0;
            alive_prev_r <= 1'b0;
            born_r       <= 1'b0;
            died_r       <= 1'b0;
        end else if (write) begin
            state_r      <= val ? 4'd1 : 4'd0;
            alive_r      <= val;
            age_r        <= '0;
            born_r       <= 1'b0;
            died_r       <= 1'b0;
        end else if (enb) begin
            state_r      <= next_state_s;
            alive_r      <= (next_state_s == 4'd1);
            alive_prev_r <= alive_r;
            born_r       <= (state_r == 4'd0) && (next_state_s == 4'd1);
            died_r       <= (state_r == 4'd1) && (next_state_s != 4'd1);
            if ((state_r == 4'd1) && (next_state_s == 4'd1)) begin
                age_r <= (age_r == AGE_MAX) ? AGE_MAX : age_r + {{(AGE_W-1){1'b0}}, 1'b1};
            end else begin
                age_r <= '0;
            end
        end else begin
            born_r       <= 1'b0;
            died_r       <= 1'b0;
        end
    end

    assign state      = state_r;
    assign alive      = alive_r;
    assign age        = age_r;
    assign alive_prev = alive_prev_r;
    assign born       = born_r;
    assign died       = died_r;

endmodule
